i2c_slave_responder: RTL
========================

Name: i2c_slave_responder

Overview:
- Clocked I2C target (responder) for the master_device bus; the other end of the master's transactions.
- Oversamples scl/sda on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs it, then either receives write bytes or transmits read bytes from a user-supplied tx_data.
- Open-drain only: drives sda low or releases it; no clock stretching.

Parameters:
- ADDRESS, 7'b1100110, 7-bit bus address this device answers to.

Ports:
- clk  input  1  system clock; oversamples the bus.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data; the block drives 1'b0 or 1'bz only.
- tx_data  input  8  byte to send on reads; sampled when tx_req pulses.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_req  output  1  one-cycle pulse when tx_data is latched into the shifter.
- busy  output  1  high from an address-matched ACK until STOP, NACK or mismatch.

Behaviour:
- Reset (async, rst=1): state IDLE, sda released (z), rx_data=0, rx_valid=0, tx_req=0, busy=0, bit counter=0, synchronizers cleared to 1.
- Bus sampling and edge detection:
  - scl and sda each pass through a 2-flop synchronizer, then a delay flop for edge detection.
  - Required bus timing: scl high and scl low each ≥4 clk periods; sda changes only while scl is low, except START/STOP.
- Bus conditions, detected on synced signals:
  - START = sda falls while scl high.
  - STOP = sda rises while scl high.
  - START/STOP take priority over any scl edge seen in the same cycle.
- Bit timing: sda is sampled on the synced scl rising edge. The block changes its sda drive only on the synced scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
- Transitions:
  - START from any state → ADDR: bit counter=0, sda released, busy=0. This also handles repeated START.
  - STOP from any state → IDLE: sda released, busy=0.
  - ADDR: shift 8 bits MSB first (7 address bits, then rw). On the 8th rising edge, compare the address with ADDRESS.
    - Mismatch → WAIT_STOP; sda stays released.
    - Match → on the next falling edge drive sda low, set busy=1, go to ADDR_ACK.
  - ADDR_ACK: on the falling edge that ends the 9th clock:
    - rw=0 → release sda, go to WRITE.
    - rw=1 → latch tx_data, pulse tx_req, drive its MSB (bit 0 → low, bit 1 → z), go to READ.
  - WRITE: shift 8 bits on rising edges. On the 8th rising edge, rx_data ← byte and rx_valid pulses for one clk. On the following falling edge drive ACK low and go to WRITE_ACK. Every byte is ACKed.
  - WRITE_ACK: on the next falling edge release sda and return to WRITE with counter=0.
  - READ: on each falling edge present the next bit, MSB first. On the falling edge after bit 0, release sda and go to READ_ACK.
  - READ_ACK: sample the master's ACK on the rising edge.
    - 0 (ACK) → on the falling edge latch the next tx_data, pulse tx_req, drive its MSB, go to READ.
    - 1 (NACK) → release sda, busy=0, go to WAIT_STOP.
  - WAIT_STOP: sda released; only START or STOP leave this state.
- Counter: 3-bit bit counter; wraps from 7 to 0 when a byte completes.
- Reset mid-transfer: sda released immediately (async); a partial byte is discarded and rx_valid does not fire.
- No scl edges ever occur in IDLE. Bus activity without a START is ignored.

Test Plan:
- Reset: rst=1 with sda driven by the bus model → sda=z, rx_data=0x00, busy=0, rx_valid=0, tx_req=0; release rst → outputs unchanged.
- Write: START, addr 1100110 + rw=0, data 0xE3, STOP → ACK (sda=0) on 9th clock after the address and after the data; rx_data=0xE3; exactly one rx_valid pulse; busy falls at STOP.
- Read:
  - Setup: tx_data=0xE3; START, addr 1100110 + rw=1; master ACKs the first byte, then NACKs the second, then STOP.
  - Required: address ACK; sda bits 1,1,1,0,0,0,1,1 on the first byte; two tx_req pulses; after the NACK sda stays z and busy=0.
- Mismatch: START, addr 0010011 + rw=0, one data byte, STOP → sda never driven low, no rx_valid, busy stays 0.
- Repeated START: write 0x5A, then START without STOP, then a read with tx_data=0x81 → rx_data=0x5A; read returns 1,0,0,0,0,0,0,1; state realigns to ADDR.
- Reset mid-read: assert rst during bit 3 of a read → sda=z within the same cycle; next START + write of 0x3C completes normally with rx_data=0x3C.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - oversampled I2C target: address match, write receive, read transmit
module i2c_slave_responder #(
  parameter logic [6:0] ADDRESS = 7'b1100110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_d;
  logic       sda_s1, sda_s2, sda_d;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] tx_shift;
  logic       rw_bit;
  logic       byte_done;
  logic       sda_low;

  logic start_cond, stop_cond, scl_rise, scl_fall;

  // Open-drain: only ever pull low or let the bus float.
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign start_cond = scl_s2 && scl_d && sda_d && !sda_s2;
  assign stop_cond  = scl_s2 && scl_d && !sda_d && sda_s2;
  assign scl_rise   = scl_s2 && !scl_d;
  assign scl_fall   = !scl_s2 && scl_d;

  // Two-flop synchronizers plus a delay stage for edge detection; idle bus is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda;    sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  // Protocol FSM: sample on synced scl rise, change drive only on synced scl fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      tx_shift  <= 8'd0;
      rw_bit    <= 1'b0;
      byte_done <= 1'b0;
      sda_low   <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_cond) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        sda_low   <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        byte_done <= 1'b0;
        sda_low   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw_bit <= sda_s2;
                if (shreg == ADDRESS) byte_done <= 1'b1;
                else                  state     <= WAIT_STOP;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_low   <= 1'b1;
              busy      <= 1'b1;
              state     <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (!rw_bit) begin
                sda_low <= 1'b0;
                state   <= WRITE;
              end else begin
                tx_shift <= {tx_data[6:0], 1'b0};
                sda_low  <= !tx_data[7];
                tx_req   <= 1'b1;
                state    <= READ;
              end
            end
          end
          WRITE: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {shreg, sda_s2};
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_low   <= 1'b1;
              state     <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= WRITE;
            end
          end
          READ: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_low <= 1'b0;
                state   <= READ_ACK;
              end else begin
                sda_low  <= !tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                sda_low <= 1'b0;
                busy    <= 1'b0;
                state   <= WAIT_STOP;
              end else begin
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd0;
              tx_shift  <= {tx_data[6:0], 1'b0};
              sda_low   <= !tx_data[7];
              tx_req    <= 1'b1;
              state     <= READ;
            end
          end
          WAIT_STOP: sda_low <= 1'b0;
          default:   sda_low <= 1'b0;
        endcase
      end
    end
  end

endmodule
